// File: rtl/led_pkg.sv
// Shared types and defaults for the LED shift-register driver.
// Holds the frame FSM encoding and the default timing parameters.
package led_pkg;

  localparam int N_LEDS = 16;
  localparam int CLK_DIV_DEF = 4;
  localparam int REFRESH_CYCLES_DEF = 40000;
  localparam int PWM_DIV_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

endpackage

// File: rtl/led_shift_driver_pwm.sv
// Global dimming: free-running PWM counter gating the output enable.
// Outputs stay dark until the first complete frame has been latched.
module led_pwm_dimmer
  import led_pkg::*;
#(
  parameter int PWM_DIV = PWM_DIV_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       blank_done,
  input  logic [3:0] brightness,
  output logic       oe_n
);

  localparam logic [7:0] PRE_MAX = 8'(PWM_DIV - 1);

  logic [7:0] pre;
  logic [3:0] pwm;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre  <= '0;
      pwm  <= '0;
      oe_n <= 1'b1;
    end else begin
      if (pre == PRE_MAX) begin
        pre <= '0;
        pwm <= pwm + 4'd1;
      end else begin
        pre <= pre + 8'd1;
      end
      oe_n <= !(blank_done &&
                (brightness == 4'hF || pwm < brightness));
    end
  end

endmodule

// File: rtl/led_shift_driver.sv
// Serialises a 16-bit LED pattern into an external shift/storage
// register pair, re-shifting on change, on request or on refresh.
module led_shift_driver
  import led_pkg::*;
#(
  parameter int CLK_DIV        = CLK_DIV_DEF,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
  parameter int PWM_DIV        = PWM_DIV_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_i,
  input  logic [3:0]        brightness_i,
  input  logic              force_update_i,
  output logic              sr_clk_o,
  output logic              sr_data_o,
  output logic              sr_latch_o,
  output logic              sr_oe_n_o,
  output logic              busy_o,
  output logic [15:0]       frame_count_o
);

  localparam logic [7:0]  DIV_MAX = 8'(CLK_DIV - 1);
  localparam logic [19:0] REF_MAX = 20'(REFRESH_CYCLES - 1);
  localparam logic [3:0]  TOP_BIT = 4'(N_LEDS - 1);

  state_t            state;
  logic [N_LEDS-1:0] shadow;
  logic [N_LEDS-1:0] shreg;
  logic [3:0]        bit_cnt;
  logic [7:0]        div;
  logic [19:0]       refresh;
  logic              pend;
  logic              blank_done;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      shadow        <= '0;
      shreg         <= '0;
      bit_cnt       <= '0;
      div           <= '0;
      refresh       <= '0;
      pend          <= 1'b0;
      blank_done    <= 1'b0;
      sr_clk_o      <= 1'b0;
      sr_data_o     <= 1'b0;
      sr_latch_o    <= 1'b0;
      busy_o        <= 1'b0;
      frame_count_o <= '0;
    end else begin
      if (force_update_i) pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (refresh != REF_MAX) refresh <= refresh + 20'd1;
          if (led_i != shadow || pend || refresh == REF_MAX) begin
            state  <= LOAD;
            busy_o <= 1'b1;
          end
        end
        LOAD: begin
          // a request landing in LOAD is served by this frame
          shadow    <= led_i;
          shreg     <= led_i;
          bit_cnt   <= TOP_BIT;
          pend      <= 1'b0;
          refresh   <= '0;
          div       <= '0;
          sr_clk_o  <= 1'b0;
          sr_data_o <= led_i[N_LEDS-1];
          state     <= SHIFT_LO;
        end
        SHIFT_LO: begin
          if (div == DIV_MAX) begin
            div      <= '0;
            sr_clk_o <= 1'b1;
            state    <= SHIFT_HI;
          end else begin
            div <= div + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div == DIV_MAX) begin
            div      <= '0;
            shreg    <= {shreg[N_LEDS-2:0], 1'b0};
            sr_clk_o <= 1'b0;
            if (bit_cnt == 4'd0) begin
              sr_data_o  <= 1'b0;
              sr_latch_o <= 1'b1;
              state      <= LATCH;
            end else begin
              bit_cnt   <= bit_cnt - 4'd1;
              sr_data_o <= shreg[N_LEDS-2];
              state     <= SHIFT_LO;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        LATCH: begin
          if (div == DIV_MAX) begin
            div           <= '0;
            sr_latch_o    <= 1'b0;
            busy_o        <= 1'b0;
            blank_done    <= 1'b1;
            frame_count_o <= frame_count_o + 16'd1;
            state         <= IDLE;
          end else begin
            div <= div + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  led_pwm_dimmer #(
    .PWM_DIV(PWM_DIV)
  ) u_dimmer (
    .clock     (clock),
    .reset     (reset),
    .blank_done(blank_done),
    .brightness(brightness_i),
    .oe_n      (sr_oe_n_o)
  );

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: frame-offset reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_led_shift_driver;

  localparam int CD    = 4;
  localparam int RC    = 100;
  localparam int PD    = 16;
  localparam int FRAME = 1 + 33 * CD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] led_i = 16'hA5C3;
  logic [3:0]  brightness_i = 4'd8;
  logic        force_update_i = 1'b0;
  logic        sr_clk_o, sr_data_o, sr_latch_o, sr_oe_n_o, busy_o;
  logic [15:0] frame_count_o;

  int tests = 0;
  int fails = 0;

  led_shift_driver #(
    .CLK_DIV(CD), .REFRESH_CYCLES(RC), .PWM_DIV(PD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .led_i         (led_i),
    .brightness_i  (brightness_i),
    .force_update_i(force_update_i),
    .sr_clk_o      (sr_clk_o),
    .sr_data_o     (sr_data_o),
    .sr_latch_o    (sr_latch_o),
    .sr_oe_n_o     (sr_oe_n_o),
    .busy_o        (busy_o),
    .frame_count_o (frame_count_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: frame described by offset k from its LOAD cycle
  bit          m_valid = 0;
  bit          m_busy, m_pend, m_blank, m_oe_n;
  int          m_k, m_idle, m_n;
  logic [15:0] m_shadow, m_pat, m_count;

  always @(posedge clock) begin
    if (!reset) begin
      m_valid = 1; m_busy = 0; m_k = 0; m_pend = 0; m_idle = 0;
      m_n = 0; m_blank = 0; m_oe_n = 1; m_shadow = 0; m_pat = 0;
      m_count = 0;
    end else begin
      m_oe_n = !(m_blank && (brightness_i == 15 ||
                 ((m_n / PD) % 16) < int'(brightness_i)));
      m_n++;
      if (!m_busy) begin
        if (led_i != m_shadow || m_pend || m_idle == RC - 1) begin
          m_busy = 1; m_k = 0;
        end
        if (m_idle < RC - 1) m_idle++;
        if (force_update_i) m_pend = 1;
      end else begin
        if (m_k == 0) begin
          m_shadow = led_i; m_pat = led_i; m_pend = 0; m_idle = 0;
        end else if (force_update_i) begin
          m_pend = 1;
        end
        m_k++;
        if (m_k == FRAME) begin
          m_busy = 0; m_count++; m_blank = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      bit sh, e_clk, e_data, e_latch;
      int idx, ph;
      sh = m_busy && m_k >= 1 && m_k <= 32 * CD;
      idx = sh ? (m_k - 1) / (2 * CD) : 0;
      ph = sh ? (m_k - 1) % (2 * CD) : 0;
      e_clk = sh && ph >= CD;
      e_data = sh ? m_pat[15 - idx] : 1'b0;
      e_latch = m_busy && m_k > 32 * CD;
      check("outputs{busy,clk,data,latch,oe_n}",
            {busy_o, sr_clk_o, sr_data_o, sr_latch_o, sr_oe_n_o},
            {m_busy, e_clk, e_data, e_latch, m_oe_n});
      check("frame_count", frame_count_o, m_count);
    end
  end

  task automatic wait_busy(input logic lvl);
    int t = 0;
    while (busy_o !== lvl && t < 500) begin
      @(negedge clock); t++;
    end
    check("wait_busy", busy_o, lvl);
  endtask

  // Waits for a frame, records shifted bits, lengths and lit cycles
  task automatic capture(input int chg_at, input logic [15:0] chg_val,
                         input bit frc, output logic [15:0] bits,
                         output int blen, output int llen,
                         output int gap, output int olow);
    logic pc = 1'b0;
    bits = '0; blen = 0; llen = 0; gap = 0; olow = 0;
    while (!busy_o && gap < 400) begin
      if (!sr_oe_n_o) olow++;
      @(negedge clock); gap++;
    end
    check("frame_start", busy_o, 1'b1);
    while (busy_o && blen < 1000) begin
      blen++;
      if (blen == chg_at) led_i = chg_val;
      force_update_i = frc && (blen == 10 || blen == 20 || blen == 30);
      if (sr_clk_o && !pc) bits = {bits[14:0], sr_data_o};
      pc = sr_clk_o;
      if (sr_latch_o) llen++;
      if (!sr_oe_n_o) olow++;
      @(negedge clock);
    end
    force_update_i = 1'b0;
  endtask

  task automatic pulse_force();
    force_update_i = 1'b1;
    @(negedge clock);
    force_update_i = 1'b0;
  endtask

  initial begin
    logic [15:0] bits;
    int blen, llen, gap, olow, low;

    repeat (3) @(negedge clock);
    check("rst_busy", busy_o, 1'b0);
    check("rst_oe_n", sr_oe_n_o, 1'b1);
    check("rst_latch", sr_latch_o, 1'b0);
    check("rst_count", frame_count_o, 16'h0);
    reset = 1'b1;

    capture(0, 16'h0, 0, bits, blen, llen, gap, olow);
    check("f1_bits", bits, 16'hA5C3);
    check("f1_busy_len", blen, 133);
    check("f1_latch_len", llen, 4);
    check("f1_dark", olow, 0);
    check("f1_count", frame_count_o, 16'd1);

    pulse_force();
    capture(50, 16'h0001, 0, bits, blen, llen, gap, olow);
    check("chg_old_bits", bits, 16'hA5C3);
    capture(0, 16'h0, 0, bits, blen, llen, gap, olow);
    check("chg_gap", gap, 1);
    check("chg_new_bits", bits, 16'h0001);
    check("chg_count", frame_count_o, 16'd3);

    pulse_force();
    capture(0, 16'h0, 1, bits, blen, llen, gap, olow);
    capture(0, 16'h0, 0, bits, blen, llen, gap, olow);
    check("frc_gap", gap, 1);
    check("frc_count", frame_count_o, 16'd5);
    capture(0, 16'h0, 0, bits, blen, llen, gap, olow);
    check("refresh_gap", gap, 100);
    check("refresh_count", frame_count_o, 16'd6);

    @(posedge clock); #2;
    force dut.frame_count_o = 16'hFFFE;
    m_count = 16'hFFFE;
    @(posedge clock); #2;
    release dut.frame_count_o;
    @(negedge clock);
    capture(0, 16'h0, 0, bits, blen, llen, gap, olow);
    check("wrap_ffff", frame_count_o, 16'hFFFF);
    capture(0, 16'h0, 0, bits, blen, llen, gap, olow);
    check("wrap_gap", gap, 100);
    check("wrap_zero", frame_count_o, 16'h0000);

    foreach (bits[i]) if (i < 3) begin
      logic [3:0] lv [3];
      int         ex [3];
      lv = '{4'd0, 4'd8, 4'd15};
      ex = '{0, 128, 256};
      brightness_i = lv[i];
      repeat (20) @(negedge clock);
      low = 0;
      repeat (256) begin
        if (!sr_oe_n_o) low++;
        @(negedge clock);
      end
      check($sformatf("duty_b%0d", lv[i]), low, ex[i]);
    end
    brightness_i = 4'd8;

    wait_busy(1'b0);
    led_i = 16'h3C3C;
    wait_busy(1'b1);
    repeat (20) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("abort_busy", busy_o, 1'b0);
    check("abort_latch", sr_latch_o, 1'b0);
    check("abort_oe_n", sr_oe_n_o, 1'b1);
    reset = 1'b1;
    capture(0, 16'h0, 0, bits, blen, llen, gap, olow);
    check("post_rst_bits", bits, 16'h3C3C);
    check("post_rst_latch", llen, 4);
    check("post_rst_dark", olow, 0);
    check("post_rst_count", frame_count_o, 16'd1);
    repeat (5) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
